piezo_melody_drv: RTL and testbench



---
 rtl/piezo_melody_drv_if.sv | 34 +++
 rtl/piezo_melody_drv.sv | 254 +++++++++++++++++++++++++
 tb/tb_piezo_melody_drv.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/piezo_melody_drv_if.sv
// -----------------------------------------------------------------------------
// piezo_melody_drv_if
// Alarm request / piezo drive bundle for piezo_melody_drv.
// The driver sits on the slave side. The requester or monitor sits on the
// master side.
// When PIEZO_VOL_EN is defined, the bundle also carries the 3-bit volume
// input vol.
// -----------------------------------------------------------------------------
interface piezo_melody_drv_if #(
    parameter int NUM_SRC = 3
);
    localparam int SRC_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] alarm_req;   // bit0 highest priority
`ifdef PIEZO_VOL_EN
    logic [2:0]         vol;         // high-phase scale, 7 = 50% duty
`endif
    logic               piezo;       // positive side of the element
    logic               piezo_n;     // negative side of the element
    logic               busy;        // melody or repeat gap in progress
    logic [SRC_W-1:0]   active_src;  // source currently being served

`ifdef PIEZO_VOL_EN
    modport master (output alarm_req, output vol,
                    input  piezo, input piezo_n, input busy, input active_src);
    modport slave  (input  alarm_req, input  vol,
                    output piezo, output piezo_n, output busy, output active_src);
`else
    modport master (output alarm_req,
                    input  piezo, input piezo_n, input busy, input active_src);
    modport slave  (input  alarm_req,
                    output piezo, output piezo_n, output busy, output active_src);
`endif
endinterface

// File: rtl/piezo_melody_drv.sv
// -----------------------------------------------------------------------------
// piezo_melody_drv
// Prioritised multi-source alarm melody player with a differential piezo drive.
//
// - Source 0 loops G6/C7/E7 with no pause.
// - Source 1 plays the fanfare backwards, then a silent gap.
// - Sources 2 and up play the fanfare forwards, then a silent gap.
// - A higher-priority request pre-empts the current note or gap at once.
// - If the served request drops, the current note still finishes, or the gap
//   ends on the next edge.
//
// Optional build macro: PIEZO_VOL_EN adds the vol[2:0] input. vol shortens
// the high phase of each tone period to ((P>>1)*(vol+1))>>3 cycles.
//
// With FAST_SIM=1, note durations and the gap are shifted right by DUR_SHIFT.
// DUR_SHIFT defaults to 6, which divides them by 64.
// NUM_SRC must match the NUM_SRC of the connected interface.
// -----------------------------------------------------------------------------
module piezo_melody_drv #(
    parameter int FAST_SIM  = 0,
    parameter int CLK_FREQ  = 50_000_000,
    parameter int NUM_SRC   = 3,
    parameter int GAP_CYC   = 150_000_000,
    parameter int DUR_SHIFT = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    piezo_melody_drv_if.slave  bus
);

    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam int SHIFT = (FAST_SIM != 0) ? DUR_SHIFT : 0;

    // Tone period = round(CLK_FREQ / f). f is given in centi-hertz so that the
    // rounding stays in integer arithmetic.
    function automatic logic [14:0] tone_period(input longint clk_hz, input longint f_chz);
        return 15'((clk_hz * 100 + f_chz / 2) / f_chz);
    endfunction

    localparam logic [14:0] PER_G6 = tone_period(longint'(CLK_FREQ), 156_798);
    localparam logic [14:0] PER_C7 = tone_period(longint'(CLK_FREQ), 209_300);
    localparam logic [14:0] PER_E7 = tone_period(longint'(CLK_FREQ), 263_702);
    localparam logic [14:0] PER_G7 = tone_period(longint'(CLK_FREQ), 313_596);

    // Each duration constant holds the last count of a note, i.e. duration - 1.
    localparam logic [24:0] DUR_4M_LAST  = 25'((32'd4_194_304  >> SHIFT) - 32'd1);
    localparam logic [24:0] DUR_8M_LAST  = 25'((32'd8_388_608  >> SHIFT) - 32'd1);
    localparam logic [24:0] DUR_12M_LAST = 25'((32'd12_582_912 >> SHIFT) - 32'd1);
    localparam logic [24:0] DUR_16M_LAST = 25'((32'd16_777_216 >> SHIFT) - 32'd1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC >> SHIFT) - 1);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_e;
    typedef enum logic [1:0] {NOTE_G6, NOTE_C7, NOTE_E7, NOTE_G7} note_e;

    state_e             state, state_nxt;
    logic [SRC_W-1:0]   active_src, src_nxt;
    logic [2:0]         note_idx, note_nxt;
    logic [24:0]        dur_cnt, dur_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_nxt;
    logic [14:0]        per_cnt, per_nxt;

    note_e              cur_note;
    logic [24:0]        cur_dur_last;
    logic               last_note;
    logic [14:0]        cur_per;
    logic [14:0]        high_len;
    logic               tone_hi;

    logic               req_any;
    logic [SRC_W-1:0]   req_top;
    logic               src_held;
    logic               preempt;

    logic               restart;
    logic [SRC_W-1:0]   restart_src;
    logic               go_idle;

    // Find the highest-priority pending request. The lowest set index wins.
    always_comb begin
        req_any = |bus.alarm_req;
        req_top = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (bus.alarm_req[i]) req_top = SRC_W'(i);
        end
    end

    assign src_held = bus.alarm_req[active_src];
    assign preempt  = (state != IDLE) && req_any && (req_top < active_src);

    // Melody ROM: map (source, note index) to a note, its last count and an
    // end-of-melody flag.
    always_comb begin
        cur_note     = NOTE_G6;
        cur_dur_last = DUR_8M_LAST;
        last_note    = 1'b0;
        if (active_src == '0) begin
            case (note_idx)
                3'd0:    cur_note = NOTE_G6;
                3'd1:    cur_note = NOTE_C7;
                default: begin cur_note = NOTE_E7; last_note = 1'b1; end
            endcase
        end else if (active_src == SRC_W'(1)) begin
            case (note_idx)
                3'd0:    begin cur_note = NOTE_G7; cur_dur_last = DUR_16M_LAST; end
                3'd1:    begin cur_note = NOTE_E7; cur_dur_last = DUR_4M_LAST;  end
                3'd2:    begin cur_note = NOTE_G7; cur_dur_last = DUR_12M_LAST; end
                3'd3:    cur_note = NOTE_E7;
                3'd4:    cur_note = NOTE_C7;
                default: begin cur_note = NOTE_G6; last_note = 1'b1; end
            endcase
        end else begin
            case (note_idx)
                3'd0:    cur_note = NOTE_G6;
                3'd1:    cur_note = NOTE_C7;
                3'd2:    cur_note = NOTE_E7;
                3'd3:    begin cur_note = NOTE_G7; cur_dur_last = DUR_12M_LAST; end
                3'd4:    begin cur_note = NOTE_E7; cur_dur_last = DUR_4M_LAST;  end
                default: begin
                    cur_note     = NOTE_G7;
                    cur_dur_last = DUR_16M_LAST;
                    last_note    = 1'b1;
                end
            endcase
        end
    end

    // Look up the tone period of the current note.
    always_comb begin
        case (cur_note)
            NOTE_G6: cur_per = PER_G6;
            NOTE_C7: cur_per = PER_C7;
            NOTE_E7: cur_per = PER_E7;
            default: cur_per = PER_G7;
        endcase
    end

    // Next-state logic: sequence notes, end gaps, pre-empt, and hand off on a
    // dropped request.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // that no path leaves a value unassigned and no latch is inferred.
        state_nxt   = state;
        src_nxt     = active_src;
        note_nxt    = note_idx;
        dur_nxt     = dur_cnt;
        gap_nxt     = gap_cnt;
        per_nxt     = per_cnt;
        restart     = 1'b0;
        restart_src = active_src;
        go_idle     = 1'b0;

        case (state)
            IDLE: begin
                if (req_any) begin
                    restart     = 1'b1;
                    restart_src = req_top;
                end
            end
            PLAY: begin
                if (preempt) begin
                    restart     = 1'b1;
                    restart_src = req_top;
                end else if (dur_cnt == cur_dur_last) begin
                    dur_nxt = '0;
                    per_nxt = '0;
                    if (!src_held) begin
                        restart     = req_any;
                        restart_src = req_top;
                        go_idle     = !req_any;
                    end else if (last_note) begin
                        note_nxt = '0;
                        if (active_src != '0) state_nxt = GAP;
                    end else begin
                        note_nxt = note_idx + 3'd1;
                    end
                end else begin
                    dur_nxt = dur_cnt + 25'd1;
                    per_nxt = (per_cnt == cur_per - 15'd1) ? '0 : per_cnt + 15'd1;
                end
            end
            GAP: begin
                if (preempt) begin
                    restart     = 1'b1;
                    restart_src = req_top;
                end else if (!src_held) begin
                    restart     = req_any;
                    restart_src = req_top;
                    go_idle     = !req_any;
                end else if (gap_cnt == GAP_LAST) begin
                    restart = 1'b1;
                end else begin
                    gap_nxt = gap_cnt + GAP_W'(1);
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (restart) begin
            state_nxt = PLAY;
            src_nxt   = restart_src;
            note_nxt  = '0;
            dur_nxt   = '0;
            gap_nxt   = '0;
            per_nxt   = '0;
        end else if (go_idle) begin
            state_nxt = IDLE;
            src_nxt   = '0;
            note_nxt  = '0;
            dur_nxt   = '0;
            gap_nxt   = '0;
            per_nxt   = '0;
        end
    end

    // State and counter registers. Reset clears them asynchronously, so the
    // drive goes silent at once.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples the values from before the edge.
        if (!rst_n) begin
            state      <= IDLE;
            active_src <= '0;
            note_idx   <= '0;
            dur_cnt    <= '0;
            gap_cnt    <= '0;
            per_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            active_src <= src_nxt;
            note_idx   <= note_nxt;
            dur_cnt    <= dur_nxt;
            gap_cnt    <= gap_nxt;
            per_cnt    <= per_nxt;
        end
    end

`ifdef PIEZO_VOL_EN
    logic [17:0] high_prod;
    assign high_prod = 18'(cur_per >> 1) * (18'(bus.vol) + 18'd1);
    assign high_len  = 15'(high_prod >> 3);
`else
    assign high_len  = cur_per >> 1;
`endif

    // Tone decode. Both sides are held low outside PLAY, so no DC voltage
    // stays across the element.
    assign tone_hi        = (per_cnt < high_len);
    assign bus.piezo      = (state == PLAY) &&  tone_hi;
    assign bus.piezo_n    = (state == PLAY) && !tone_hi;
    assign bus.busy       = (state != IDLE);
    assign bus.active_src = active_src;

endmodule

// File: tb/tb_piezo_melody_drv.sv
// -----------------------------------------------------------------------------
// tb_piezo_melody_drv
// Directed bench for piezo_melody_drv.
//
// Settings: FAST_SIM=1, DUR_SHIFT=12, CLK_FREQ=500 kHz, GAP_CYC=8e6.
// Hand-derived values at these settings:
//   periods   G6=319  C7=239  E7=190  G7=159
//   durations 2^22->1024  2^23->2048  2^23+2^22->3072  2^24->4096
//   gap       8e6>>12 = 1953
//   fanfare   14336 cycles
//   src0 loop 6144 cycles
// -----------------------------------------------------------------------------
module tb_piezo_melody_drv;

    localparam int NUM_SRC = 3;
    localparam int P_G6 = 319, P_C7 = 239, P_E7 = 190, P_G7 = 159;
    localparam int D4 = 1024, D8 = 2048, D12 = 3072, D16 = 4096;
    localparam int GAP_LEN = 1953;
    localparam int FANFARE = 14336;
    localparam int LOOP0   = 6144;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   vol_now  = 7;

    always #5 clk = ~clk;

    piezo_melody_drv_if #(.NUM_SRC(NUM_SRC)) bus ();

    piezo_melody_drv #(
        .FAST_SIM (1),
        .CLK_FREQ (500_000),
        .NUM_SRC  (NUM_SRC),
        .GAP_CYC  (8_000_000),
        .DUR_SHIFT(12)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected piezo level at cycle t of a melody (t=0 is the first PLAY cycle).
    function automatic logic model_piezo(input int src, input int t, input int v);
        int per[6];
        int dur[6];
        int cnt;
        int tt;
        if (src == 0) begin
            per = '{P_G6, P_C7, P_E7, 1, 1, 1};
            dur = '{D8, D8, D8, 0, 0, 0};
            cnt = 3;
            tt  = t % LOOP0;
        end else if (src == 1) begin
            per = '{P_G7, P_E7, P_G7, P_E7, P_C7, P_G6};
            dur = '{D16, D4, D12, D8, D8, D8};
            cnt = 6;
            tt  = t;
        end else begin
            per = '{P_G6, P_C7, P_E7, P_G7, P_E7, P_G7};
            dur = '{D8, D8, D8, D12, D4, D16};
            cnt = 6;
            tt  = t;
        end
        for (int k = 0; k < cnt; k++) begin
            if (tt < dur[k]) return (tt % per[k]) < (((per[k] >> 1) * (v + 1)) >> 3);
            tt -= dur[k];
        end
        return 1'b0;
    endfunction

    // Compare n consecutive cycles against the model, starting at melody time
    // t0. The task is entered at a negedge and returns at a negedge.
    task automatic play_check(input string tag, input int src, input int t0, input int n, input int v);
        int   errs = 0;
        logic exp_p;
        for (int t = t0; t < t0 + n; t++) begin
            exp_p = model_piezo(src, t, v);
            if (bus.piezo !== exp_p || bus.piezo_n !== !exp_p || bus.busy !== 1'b1 ||
                bus.active_src !== 2'(src))
                errs++;
            @(negedge clk);
        end
        check(tag, errs, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        logic quiet;

        rst_n         = 1'b0;
        bus.alarm_req = '0;
`ifdef PIEZO_VOL_EN
        bus.vol       = 3'd7;
`endif
        repeat (3) @(negedge clk);
        check("rst_piezo",   bus.piezo,      0);
        check("rst_piezo_n", bus.piezo_n,    0);
        check("rst_busy",    bus.busy,       0);
        check("rst_src",     bus.active_src, 0);
        rst_n = 1'b1;

        // No requests: everything must stay quiet.
        quiet = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.piezo !== 1'b0 || bus.piezo_n !== 1'b0 || bus.busy !== 1'b0 ||
                bus.active_src !== 2'd0)
                quiet = 1'b0;
        end
        check("idle_quiet_100", quiet, 1);

        // src2: busy rises one edge later, then the full fanfare, the gap and the replay.
        bus.alarm_req = 3'b100;
        #1;
        check("busy_before_edge", bus.busy, 0);
        @(negedge clk);
        check("busy_after_edge", bus.busy, 1);
        check("src2_selected", bus.active_src, 2);
        play_check("src2_fanfare", 2, 0, FANFARE, vol_now);
        check("gap_piezo",   bus.piezo,   0);
        check("gap_piezo_n", bus.piezo_n, 0);
        check("gap_busy",    bus.busy,    1);
        n = 0;
        while (bus.busy && !bus.piezo && !bus.piezo_n && n < 5000) begin
            n++;
            @(negedge clk);
        end
        check("gap_length", n, GAP_LEN);
        check("replay_starts_high", bus.piezo, 1);
        play_check("src2_replay", 2, 0, 3000, vol_now);

        // Pre-emption by src0 in mid-note, then its gapless loop (bit2 stays set and is ignored).
        bus.alarm_req = 3'b101;
        @(negedge clk);
        check("preempt_src0", bus.active_src, 0);
        play_check("src0_loop", 0, 0, 2 * LOOP0 + 3000, vol_now);

        // Drop bit0 in mid-C7: C7 finishes, then src2 follows with no gap.
        bus.alarm_req = 3'b100;
        play_check("src0_c7_completes", 0, 2 * LOOP0 + 3000, 1096, vol_now);
        check("handoff_src2", bus.active_src, 2);
        play_check("src2_after_handoff", 2, 0, 500, vol_now);

        // Asynchronous reset in mid-note.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_piezo",   bus.piezo,      0);
        check("async_rst_piezo_n", bus.piezo_n,    0);
        check("async_rst_busy",    bus.busy,       0);
        check("async_rst_src",     bus.active_src, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_idle", bus.busy, 0);
        @(negedge clk);
        play_check("post_rst_replay", 2, 0, 400, vol_now);

`ifdef PIEZO_VOL_EN
        // vol=1: the G7 high phase becomes (79*2)>>3 = 19 of 159 cycles.
        vol_now = 1;
        bus.vol = 3'd1;
        play_check("vol1_duty", 2, 400, 9000, vol_now);
        vol_now = 7;
        bus.vol = 3'd7;
`endif

        // src1 pre-empts src2 and plays the reversed fanfare.
        bus.alarm_req = 3'b110;
        @(negedge clk);
        play_check("src1_reverse", 1, 0, 5200, vol_now);

        // Drop every request in mid-G7: the note ends after 2992 more cycles, then IDLE.
        bus.alarm_req = 3'b000;
        n = 0;
        while (bus.busy && n < 10000) begin
            n++;
            @(negedge clk);
        end
        check("drop_to_idle_cycles", n, 2992);
        check("idle_piezo",   bus.piezo,   0);
        check("idle_piezo_n", bus.piezo_n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
